// File: rtl/heap_array_unit.sv
// Array-memory engine for the executor: allocates, frees and indexes fixed-size arrays in one heap RAM.
// Optional HEAP_ARRAY_TRACE_EN adds a per-response trace line, an error counter and a freed-stack check.
module heap_array_unit #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 8,
    parameter int NArea              = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [MemoryElementWidth-1:0] cmd_array,
    input  logic [MemoryElementWidth-1:0] cmd_index,
    input  logic [MemoryElementWidth-1:0] cmd_data,
    output logic                          rsp_valid,
    output logic [MemoryElementWidth-1:0] rsp_data,
    output logic                          rsp_error,
    output logic [MemoryElementWidth-1:0] allocs
);
    localparam int W     = MemoryElementWidth;
    localparam int Depth = NArrays * NArea;
    localparam int AW    = $clog2(Depth);
    localparam int AIW   = (NArrays > 1) ? $clog2(NArrays) : 1;

    localparam logic [2:0] OpAlloc = 3'd0;
    localparam logic [2:0] OpFree  = 3'd1;
    localparam logic [2:0] OpPush  = 3'd2;
    localparam logic [2:0] OpPop   = 3'd3;
    localparam logic [2:0] OpRead  = 3'd4;
    localparam logic [2:0] OpWrite = 3'd5;
    localparam logic [2:0] OpSize  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   array_q, array_d;
    logic [W-1:0]   index_q, index_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   sizes_q [NArrays];
    logic [W-1:0]   sizes_d [NArrays];
    logic [W-1:0]   stack_q [NArrays];
    logic [W-1:0]   stack_d [NArrays];
    logic [NArrays-1:0] bitmap_q, bitmap_d;
    logic [W-1:0]   top_q, top_d;
    logic [W-1:0]   allocs_q, allocs_d;
    logic           rspErr_q, rspErr_d;
    logic [W-1:0]   rspData_q, rspData_d;
    logic           useRam_q, useRam_d;

    logic [W-1:0]   heapMem [Depth];
    logic [W-1:0]   ramRdata_q;
    logic           ramWe, ramRe;
    logic [AW-1:0]  ramAddr;
    logic [W-1:0]   ramWdata;

    logic [AIW-1:0] arrIdx;
    logic           arrOk, isAlloc;
    logic [W-1:0]   curSize;
    logic [W-1:0]   off;
    logic           err;
    logic [W-1:0]   res;
    logic [W-1:0]   newNum;

    // Error checks are evaluated first; state is only touched on the success path.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        array_d   = array_q;
        index_d   = index_q;
        data_d    = data_q;
        sizes_d   = sizes_q;
        stack_d   = stack_q;
        bitmap_d  = bitmap_q;
        top_d     = top_q;
        allocs_d  = allocs_q;
        rspErr_d  = rspErr_q;
        rspData_d = rspData_q;
        useRam_d  = useRam_q;
        ramWe     = 1'b0;
        ramRe     = 1'b0;
        ramWdata  = data_q;
        off       = '0;
        err       = 1'b0;
        res       = '0;
        newNum    = '0;
        arrIdx    = array_q[AIW-1:0];
        arrOk     = array_q < W'(NArrays);
        isAlloc   = arrOk && bitmap_q[arrIdx];
        curSize   = sizes_q[arrIdx];

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    array_d = cmd_array;
                    index_d = cmd_index;
                    data_d  = cmd_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d  = RESP;
                useRam_d = 1'b0;
                case (op_q)
                    OpAlloc: begin
                        if (top_q != '0) begin
                            newNum = stack_q[AIW'(top_q - 1'b1)];
                            top_d  = top_q - 1'b1;
                        end else if (allocs_q < W'(NArrays)) begin
                            newNum   = allocs_q;
                            allocs_d = allocs_q + 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                        if (!err) begin
                            sizes_d[newNum[AIW-1:0]]  = '0;
                            bitmap_d[newNum[AIW-1:0]] = 1'b1;
                            res = newNum;
                        end
                    end
                    OpFree: begin
                        if (!isAlloc) begin
                            err = 1'b1;
                        end else begin
                            bitmap_d[arrIdx]         = 1'b0;
                            stack_d[top_q[AIW-1:0]]  = array_q;
                            top_d                    = top_q + 1'b1;
                        end
                    end
                    OpPush: begin
                        if (!isAlloc || curSize == W'(NArea)) begin
                            err = 1'b1;
                        end else begin
                            off             = curSize;
                            ramWe           = 1'b1;
                            sizes_d[arrIdx] = curSize + 1'b1;
                        end
                    end
                    OpPop: begin
                        if (!isAlloc || curSize == '0) begin
                            err = 1'b1;
                        end else begin
                            off             = curSize - 1'b1;
                            ramRe           = 1'b1;
                            useRam_d        = 1'b1;
                            sizes_d[arrIdx] = curSize - 1'b1;
                        end
                    end
                    OpRead: begin
                        if (!isAlloc || index_q >= curSize) begin
                            err = 1'b1;
                        end else begin
                            off      = index_q;
                            ramRe    = 1'b1;
                            useRam_d = 1'b1;
                        end
                    end
                    OpWrite: begin
                        if (!isAlloc || index_q >= W'(NArea)) begin
                            err = 1'b1;
                        end else begin
                            off   = index_q;
                            ramWe = 1'b1;
                            if (index_q >= curSize) begin
                                sizes_d[arrIdx] = index_q + 1'b1;
                            end
                        end
                    end
                    OpSize: begin
                        if (!isAlloc) begin
                            err = 1'b1;
                        end else begin
                            res = curSize;
                        end
                    end
                    default: err = 1'b1;
                endcase
                rspErr_d  = err;
                rspData_d = err ? '0 : res;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ramAddr = AW'(int'(arrIdx) * NArea + int'(off));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            array_q   <= '0;
            index_q   <= '0;
            data_q    <= '0;
            bitmap_q  <= '0;
            top_q     <= '0;
            allocs_q  <= '0;
            rspErr_q  <= 1'b0;
            rspData_q <= '0;
            useRam_q  <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                sizes_q[i] <= '0;
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            array_q   <= array_d;
            index_q   <= index_d;
            data_q    <= data_d;
            bitmap_q  <= bitmap_d;
            top_q     <= top_d;
            allocs_q  <= allocs_d;
            rspErr_q  <= rspErr_d;
            rspData_q <= rspData_d;
            useRam_q  <= useRam_d;
            for (int i = 0; i < NArrays; i++) begin
                sizes_q[i] <= sizes_d[i];
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // Heap contents survive reset; only the bookkeeping above is cleared.
    always_ff @(posedge clock) begin
        if (ramWe) begin
            heapMem[ramAddr] <= ramWdata;
        end
        if (ramRe) begin
            ramRdata_q <= heapMem[ramAddr];
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? (useRam_q ? ramRdata_q : rspData_q) : '0;
    assign rsp_error = rsp_valid & rspErr_q;
    assign allocs    = allocs_q;

`ifdef HEAP_ARRAY_TRACE_EN
    integer errCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            errCount <= 0;
        end else if (rsp_valid) begin
            $display("heap_array_unit: op=%0d array=%0d index=%0d data=%0d rsp_data=%0d rsp_error=%0b",
                     op_q, array_q, index_q, data_q, rsp_data, rsp_error);
            if (rsp_error) begin
                errCount <= errCount + 1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && top_q > W'(NArrays)) begin
            $error("heap_array_unit: freed-stack top %0d exceeds %0d", top_q, NArrays);
        end
    end
`endif

endmodule

// File: tb/tb_heap_array_unit.sv
// Scoreboard bench for heap_array_unit: directed scenarios plus random commands against an array-level model.
module tb_heap_array_unit;
    localparam int W  = 12;
    localparam int NA = 8;
    localparam int NE = 16;

    localparam int OpAlloc = 0;
    localparam int OpFree  = 1;
    localparam int OpPush  = 2;
    localparam int OpPop   = 3;
    localparam int OpRead  = 4;
    localparam int OpWrite = 5;
    localparam int OpSize  = 6;
    localparam int OpRsvd  = 7;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_array;
    logic [W-1:0] cmd_index;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_error;
    logic [W-1:0] allocs;

    heap_array_unit #(.MemoryElementWidth(W), .NArrays(NA), .NArea(NE)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_array(cmd_array), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .allocs(allocs)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        bit           dc;
        int           acc;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Reference model kept at array granularity.
    int mSize   [NA];
    bit mAlloc  [NA];
    int mFreed  [$];
    int mAllocs;
    int mHeap   [NA][NE];
    bit mKnown  [NA][NE];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NA; i++) begin
            mSize[i]  = 0;
            mAlloc[i] = 1'b0;
        end
        mFreed.delete();
        mAllocs = 0;
    endtask

    task automatic modelExec(input int op, input int arr, input int idx, input int data,
                             output int rd, output bit er, output bit dc);
        bit ok;
        rd = 0;
        er = 1'b0;
        dc = 1'b0;
        ok = (arr < NA) ? mAlloc[arr] : 1'b0;
        case (op)
            OpAlloc: begin
                if (mFreed.size() > 0)  rd = mFreed.pop_back();
                else if (mAllocs < NA) begin rd = mAllocs; mAllocs++; end
                else                    er = 1'b1;
                if (!er) begin
                    mAlloc[rd] = 1'b1;
                    mSize[rd]  = 0;
                end
            end
            OpFree: begin
                if (!ok) er = 1'b1;
                else begin
                    mAlloc[arr] = 1'b0;
                    mFreed.push_back(arr);
                end
            end
            OpPush: begin
                if (!ok || mSize[arr] == NE) er = 1'b1;
                else begin
                    mHeap[arr][mSize[arr]]  = data;
                    mKnown[arr][mSize[arr]] = 1'b1;
                    mSize[arr]++;
                end
            end
            OpPop: begin
                if (!ok || mSize[arr] == 0) er = 1'b1;
                else begin
                    mSize[arr]--;
                    rd = mHeap[arr][mSize[arr]];
                    dc = !mKnown[arr][mSize[arr]];
                end
            end
            OpRead: begin
                if (!ok || idx >= mSize[arr]) er = 1'b1;
                else begin
                    rd = mHeap[arr][idx];
                    dc = !mKnown[arr][idx];
                end
            end
            OpWrite: begin
                if (!ok || idx >= NE) er = 1'b1;
                else begin
                    mHeap[arr][idx]  = data;
                    mKnown[arr][idx] = 1'b1;
                    if (idx + 1 > mSize[arr]) mSize[arr] = idx + 1;
                end
            end
            OpSize: begin
                if (!ok) er = 1'b1;
                else     rd = mSize[arr];
            end
            default: er = 1'b1;
        endcase
        if (er) rd = 0;
    endtask

    task automatic waitReady(output bit ok);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        ok = cmd_ready;
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL cmd_ready_timeout: got 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic applyStimulus(input int op, input int arr, input int idx, input int data);
        bit   ok;
        int   rd;
        bit   er, dc;
        exp_t e;
        waitReady(ok);
        if (!ok) return;
        cmd_op    = op[2:0];
        cmd_array = arr[W-1:0];
        cmd_index = idx[W-1:0];
        cmd_data  = data[W-1:0];
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        modelExec(op, arr, idx, data, rd, er, dc);
        e.data = rd[W-1:0];
        e.err  = er;
        e.dc   = dc;
        e.acc  = cyc;
        expQ.push_back(e);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        checkOutput("drain", expQ.size(), 0);
    endtask

    task automatic doReset();
        waitDrain();
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every response must match the oldest outstanding expectation, 2 cycles after accept.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 data=%0d, expected no response", rsp_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
                if (!e.dc) checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                checkOutput("latency", cyc + 1 - e.acc, 2);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int r, op, arr, idx, data;
        bit ok;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_array = '0;
        cmd_index = '0;
        cmd_data  = '0;
        for (int a = 0; a < NA; a++)
            for (int i = 0; i < NE; i++) begin
                mHeap[a][i]  = 0;
                mKnown[a][i] = 1'b0;
            end
        modelReset();
        #12;
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_data",  32'(rsp_data),  0);
        checkOutput("reset_rsp_error", 32'(rsp_error), 0);
        checkOutput("reset_allocs",    32'(allocs),    0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] basic push/pop");
        applyStimulus(OpAlloc, 0, 0, 0);
        applyStimulus(OpPush, 0, 0, 1);
        applyStimulus(OpPush, 0, 0, 2);
        applyStimulus(OpPop, 0, 0, 0);
        applyStimulus(OpPop, 0, 0, 0);
        doReset();

        $display("[TB] allocation limit and LIFO reuse");
        for (int i = 0; i < NA + 1; i++) applyStimulus(OpAlloc, 0, 0, 0);
        waitDrain();
        checkOutput("allocs_full", 32'(allocs), NA);
        applyStimulus(OpFree, 3, 0, 0);
        applyStimulus(OpFree, 5, 0, 0);
        applyStimulus(OpAlloc, 0, 0, 0);
        applyStimulus(OpAlloc, 0, 0, 0);

        $display("[TB] full array and empty pop");
        for (int i = 1; i <= NE; i++) applyStimulus(OpPush, 0, 0, i);
        applyStimulus(OpPush, 0, 0, 99);
        applyStimulus(OpSize, 0, 0, 0);
        applyStimulus(OpPop, 1, 0, 0);
        applyStimulus(OpSize, 1, 0, 0);

        $display("[TB] sparse write");
        applyStimulus(OpWrite, 1, 5, 7);
        applyStimulus(OpSize, 1, 0, 0);
        applyStimulus(OpRead, 1, 5, 0);
        applyStimulus(OpRead, 1, 6, 0);
        applyStimulus(OpWrite, 1, 16, 3);
        applyStimulus(OpRead, 0, 4095, 0);
        applyStimulus(OpSize, 4095, 0, 0);

        $display("[TB] double free and reserved op");
        applyStimulus(OpFree, 2, 0, 0);
        applyStimulus(OpFree, 2, 0, 0);
        applyStimulus(OpPush, 2, 0, 4);
        applyStimulus(OpRead, 2, 0, 0);
        applyStimulus(OpSize, 2, 0, 0);
        applyStimulus(OpRsvd, 0, 0, 0);
        waitDrain();

        $display("[TB] reset during execute");
        waitReady(ok);
        if (ok) begin
            cmd_op    = 3'(OpPush);
            cmd_array = '0;
            cmd_index = '0;
            cmd_data  = 12'd55;
            cmd_valid = 1'b1;
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
            reset     = 1'b1;
            modelReset();
            #1;
            checkOutput("abort_cmd_ready", 32'(cmd_ready), 1);
            checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
            checkOutput("abort_allocs",    32'(allocs),    0);
            @(negedge clock);
            reset = 1'b0;
            repeat (3) @(negedge clock);
        end
        applyStimulus(OpSize, 0, 0, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 15) op = OpAlloc;
            else if (r < 25) op = OpFree;
            else if (r < 45) op = OpPush;
            else if (r < 55) op = OpPop;
            else if (r < 70) op = OpRead;
            else if (r < 85) op = OpWrite;
            else if (r < 97) op = OpSize;
            else             op = OpRsvd;
            arr  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 9);
            idx  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 17);
            data = $urandom_range(0, 4095);
            applyStimulus(op, arr, idx, data);
        end
        waitDrain();
        checkOutput("allocs_final", 32'(allocs), mAllocs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
